// File: rtl/range_arb_pkg.sv
// Shared types for the range table arbiter: FSM state encoding and address type.
package range_arb_pkg;
    localparam int ADDR_W = 32;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef enum logic [1:0] {IDLE, WRITE, LOOKUP, RESP} state_t;
endpackage

// File: rtl/range_arb_rr.sv
// Round-robin grant: the search starts at ptr; returns a one-hot grant and the pointer past the winner.
module range_arb_rr #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] next_ptr
);
    int   idx;
    logic found;

    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                next_ptr   = PTR_W'((idx + 1) % NREQ);
            end
        end
    end
endmodule

// File: rtl/range_table_arbiter.sv
// Serialises allocation writes and NREQ lookups onto a single-port range table.
// Define RANGE_ARB_STATS_EN to enable the saturating hit/miss counters.
module range_table_arbiter
    import range_arb_pkg::*;
#(
    parameter int NREQ         = 2,
    parameter int DEPTH        = 64,
    parameter int MAX_WR_BURST = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       alloc_valid_i,
    output logic                       alloc_ready_o,
    input  logic [ADDR_W-1:0]          alloc_first_i,
    input  logic [ADDR_W-1:0]          alloc_last_i,
    output logic                       alloc_err_o,
    input  logic [NREQ-1:0]            lkp_valid_i,
    output logic [NREQ-1:0]            lkp_ready_o,
    input  logic [NREQ*ADDR_W-1:0]     lkp_addr_i,
    output logic [NREQ-1:0]            rsp_valid_o,
    output logic                       rsp_in_range_o,
    output logic                       buf_en_write_o,
    output logic [ADDR_W-1:0]          buf_addr_first_o,
    output logic [ADDR_W-1:0]          buf_addr_last_o,
    output logic                       buf_find_o,
    output logic [ADDR_W-1:0]          buf_find_addr_o,
    input  logic                       buf_in_range_i,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
    output logic [31:0]                hit_cnt_o,
    output logic [31:0]                miss_cnt_o
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int BW    = $clog2(MAX_WR_BURST + 1);

    state_t           state;
    logic [PTR_W-1:0] rr_ptr, rr_next;
    logic [NREQ-1:0]  rr_grant, gnt_q;
    logic [BW-1:0]    burst;
    logic             idle, lkp_any, wr_wins, lkp_gnt;
    addr_t            sel_addr;

    range_arb_rr #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr (
        .req      (lkp_valid_i),
        .ptr      (rr_ptr),
        .grant    (rr_grant),
        .next_ptr (rr_next)
    );

    // Writes win unless they have starved a pending lookup for a full burst.
    assign idle          = (state == IDLE) && !rst_i;
    assign lkp_any       = |lkp_valid_i;
    assign wr_wins       = alloc_valid_i && !((burst == BW'(MAX_WR_BURST)) && lkp_any);
    assign alloc_ready_o = idle && wr_wins;
    assign lkp_ready_o   = (idle && !wr_wins) ? rr_grant : '0;
    assign lkp_gnt       = |lkp_ready_o;

    always_comb begin
        sel_addr = '0;
        for (int r = 0; r < NREQ; r++)
            if (rr_grant[r]) sel_addr = lkp_addr_i[r*ADDR_W +: ADDR_W];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            burst            <= '0;
            gnt_q            <= '0;
            occupancy_o      <= '0;
            alloc_err_o      <= 1'b0;
            buf_en_write_o   <= 1'b0;
            buf_addr_first_o <= '0;
            buf_addr_last_o  <= '0;
            buf_find_o       <= 1'b0;
            buf_find_addr_o  <= '0;
            rsp_valid_o      <= '0;
            rsp_in_range_o   <= 1'b0;
        end else begin
            alloc_err_o    <= 1'b0;
            buf_en_write_o <= 1'b0;
            buf_find_o     <= 1'b0;
            rsp_valid_o    <= '0;
            rsp_in_range_o <= 1'b0;

            if (lkp_gnt || !lkp_any) burst <= '0;
            else if (alloc_ready_o)  burst <= burst + 1'b1;

            case (state)
                IDLE: begin
                    if (alloc_ready_o) begin
                        buf_addr_first_o <= alloc_first_i;
                        buf_addr_last_o  <= alloc_last_i;
                        if (alloc_first_i > alloc_last_i) alloc_err_o    <= 1'b1;
                        else                              buf_en_write_o <= 1'b1;
                        state <= WRITE;
                    end else if (lkp_gnt) begin
                        buf_find_o      <= 1'b1;
                        buf_find_addr_o <= sel_addr;
                        gnt_q           <= rr_grant;
                        rr_ptr          <= rr_next;
                        state           <= LOOKUP;
                    end
                end
                WRITE: begin
                    // Table wraps on overflow, so occupancy simply saturates.
                    if (buf_en_write_o && occupancy_o != OCC_W'(DEPTH))
                        occupancy_o <= occupancy_o + 1'b1;
                    state <= IDLE;
                end
                LOOKUP: begin
                    rsp_valid_o    <= gnt_q;
                    rsp_in_range_o <= buf_in_range_i;
                    state          <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RANGE_ARB_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (state == RESP) begin
            if (rsp_in_range_o) begin
                if (hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + 1'b1;
            end else begin
                if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 1'b1;
            end
        end
    end
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif
endmodule

// File: tb/tb_range_table_arbiter.sv
// Directed scoreboard bench; the bench also plays the role of the attached range table.
module tb_range_table_arbiter;
    localparam int NREQ = 2;
    localparam int DEPTH = 8;

    logic        clk = 0, rst = 1;
    logic        alloc_valid = 0, alloc_ready, alloc_err;
    logic [31:0] alloc_first = 0, alloc_last = 0;
    logic [1:0]  lkp_valid = 0, lkp_ready, rsp_valid;
    logic [63:0] lkp_addr = 0;
    logic        rsp_in_range, buf_en_write, buf_find, buf_in_range;
    logic [31:0] buf_first, buf_last, buf_find_addr, hit_cnt, miss_cnt;
    logic [3:0]  occupancy;

    range_table_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .MAX_WR_BURST(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready),
        .alloc_first_i(alloc_first), .alloc_last_i(alloc_last), .alloc_err_o(alloc_err),
        .lkp_valid_i(lkp_valid), .lkp_ready_o(lkp_ready), .lkp_addr_i(lkp_addr),
        .rsp_valid_o(rsp_valid), .rsp_in_range_o(rsp_in_range),
        .buf_en_write_o(buf_en_write), .buf_addr_first_o(buf_first), .buf_addr_last_o(buf_last),
        .buf_find_o(buf_find), .buf_find_addr_o(buf_find_addr), .buf_in_range_i(buf_in_range),
        .occupancy_o(occupancy), .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural range table: wraps after DEPTH entries.
    logic [31:0] tf [DEPTH];
    logic [31:0] tl [DEPTH];
    bit          tv [DEPTH];
    int          wp = 0;
    initial for (int i = 0; i < DEPTH; i++) begin tf[i] = 0; tl[i] = 0; tv[i] = 0; end
    always @(posedge clk) if (buf_en_write) begin
        tf[wp] <= buf_first; tl[wp] <= buf_last; tv[wp] <= 1'b1;
        wp <= (wp + 1) % DEPTH;
    end
    always_comb begin
        buf_in_range = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (buf_find && tv[i] && buf_find_addr >= tf[i] && buf_find_addr <= tl[i]) buf_in_range = 1'b1;
    end

    int vectors = 0, miscompares = 0, exp_hits = 0, exp_miss = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        vectors++; miscompares++;
        $display("FAIL %s: timed out waiting for ready (cycle %0d)", name, cyc);
    endtask

    typedef struct { int r; bit inr; int cyc; } exp_t;
    exp_t sb[$];

    // Monitor: every response strobe pops one expectation.
    always @(negedge clk) if (!rst) begin
        if (rsp_valid != 0) begin
            if (sb.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL rsp_unexpected: got valid %b expected none (cycle %0d)", rsp_valid, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_valid", rsp_valid, 64'(2'b01 << e.r));
                chk("rsp_in_range", rsp_in_range, e.inr);
                chk("rsp_cycle", cyc, e.cyc);
                if (e.inr) exp_hits++; else exp_miss++;
            end
        end else chk("rsp_idle_zero", rsp_in_range, 0);
    end

    task automatic do_write(input logic [31:0] f, input logic [31:0] l, input bit err);
        int t = 0;
        @(negedge clk); alloc_valid = 1; alloc_first = f; alloc_last = l;
        #1;
        while (!alloc_ready && t < 50) begin @(negedge clk); #1; t++; end
        if (!alloc_ready) timeout("wr_ready");
        @(negedge clk); alloc_valid = 0; #1;
        chk("wr_en", buf_en_write, !err);
        chk("wr_err", alloc_err, err);
        if (!err) begin
            chk("wr_first", buf_first, f);
            chk("wr_last", buf_last, l);
        end
        @(negedge clk); #1;
        chk("wr_en_off", buf_en_write, 0);
        chk("wr_err_off", alloc_err, 0);
    endtask

    task automatic do_lookup(input int r, input logic [31:0] a, input bit inr);
        int t = 0;
        exp_t e;
        @(negedge clk); lkp_valid[r] = 1; lkp_addr[r*32 +: 32] = a;
        #1;
        while (!lkp_ready[r] && t < 50) begin @(negedge clk); #1; t++; end
        if (!lkp_ready[r]) timeout("lkp_ready");
        chk("lkp_gnt", lkp_ready, 64'(2'b01 << r));
        e.r = r; e.inr = inr; e.cyc = cyc + 2;
        sb.push_back(e);
        @(negedge clk); lkp_valid[r] = 0; #1;
        chk("find_strobe", buf_find, 1);
        chk("find_addr", buf_find_addr, a);
        @(negedge clk); @(negedge clk);
    endtask

    logic [1:0] t3_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [2:0] t4_exp [7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b010, 3'b100, 3'b100};

    initial begin
        int t, got;
        exp_t e;
        repeat (3) @(negedge clk);
        rst = 0; #1;
        chk("rst_alloc_ready", alloc_ready, 0);
        chk("rst_lkp_ready", lkp_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_en_write", buf_en_write, 0);
        chk("rst_find", buf_find, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_hit", hit_cnt, 0);

        // 1: write then in-range lookup
        do_write(32'h1000, 32'h10FF, 0);
        chk("occ_1", occupancy, 1);
        do_lookup(0, 32'h1080, 1);
        // 2: interval boundaries
        do_lookup(1, 32'h1100, 0);
        do_lookup(0, 32'h10FF, 1);
        do_lookup(0, 32'h1000, 1);
        do_lookup(1, 32'h0FFF, 0);

        // 3: both requesters held; round robin alternates starting at req0
        @(negedge clk); lkp_valid = 2'b11; lkp_addr = {32'h2000, 32'h1010};
        got = 0; t = 0;
        while (got < 4 && t < 100) begin
            #1;
            if (lkp_ready != 0) begin
                chk("t3_order", lkp_ready, t3_exp[got]);
                e.r = lkp_ready[1] ? 1 : 0; e.inr = !lkp_ready[1]; e.cyc = cyc + 2;
                sb.push_back(e);
                got++;
            end
            @(negedge clk); t++;
            if (got == 4) lkp_valid = 0;
        end
        if (got < 4) timeout("t3_grants");
        repeat (4) @(negedge clk);

        // 4: write burst limit with req1 pending
        alloc_valid = 1; alloc_first = 32'h3000; alloc_last = 32'h30FF;
        lkp_valid = 2'b10; lkp_addr[63:32] = 32'h3010;
        got = 0; t = 0;
        while (got < 7 && t < 100) begin
            #1;
            if (alloc_ready || lkp_ready != 0) begin
                chk("t4_order", {alloc_ready, lkp_ready}, t4_exp[got]);
                if (lkp_ready[1]) begin
                    e.r = 1; e.inr = 1; e.cyc = cyc + 2;
                    sb.push_back(e);
                end
                got++;
            end
            @(negedge clk); t++;
            if (got >= 5) lkp_valid = 0;
            if (got == 7) alloc_valid = 0;
        end
        if (got < 7) timeout("t4_grants");
        repeat (3) @(negedge clk);
        chk("occ_7", occupancy, 7);

        // 5: inverted interval rejected; single-address interval legal
        do_write(32'h2000, 32'h1FFF, 1);
        chk("occ_err", occupancy, 7);
        do_write(32'h5000, 32'h5000, 0);
        chk("occ_full", occupancy, DEPTH);
        do_lookup(0, 32'h5000, 1);
        do_lookup(1, 32'h5001, 0);

        // 6: saturation after DEPTH+3 writes
        for (int i = 0; i < 3; i++) do_write(32'h6000 + 32'(i) * 32'h100, 32'h60FF + 32'(i) * 32'h100, 0);
        chk("occ_sat", occupancy, DEPTH);

        t = 0;
        while (sb.size() != 0 && t < 20) begin @(negedge clk); t++; end
        chk("sb_drained", sb.size(), 0);
`ifdef RANGE_ARB_STATS_EN
        chk("hit_cnt", hit_cnt, exp_hits);
        chk("miss_cnt", miss_cnt, exp_miss);
`else
        chk("hit_cnt_tied", hit_cnt, 0);
        chk("miss_cnt_tied", miss_cnt, 0);
`endif

        // reset while a lookup is in flight: no response may follow
        @(negedge clk); lkp_valid[0] = 1; lkp_addr[31:0] = 32'h5000;
        #1; t = 0;
        while (!lkp_ready[0] && t < 50) begin @(negedge clk); #1; t++; end
        if (!lkp_ready[0]) timeout("rst_lkp_ready");
        @(negedge clk); lkp_valid = 0; #1;
        chk("rst_mid_find", buf_find, 1);
        rst = 1; #1;
        chk("rst_mid_find_off", buf_find, 0);
        chk("rst_mid_rsp", rsp_valid, 0);
        chk("rst_mid_occ", occupancy, 0);
        chk("rst_mid_hit", hit_cnt, 0);
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (4) @(negedge clk); #1;
        chk("post_rst_rsp", rsp_valid, 0);
        chk("post_rst_occ", occupancy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
